forward_pipe: RTL and testbench

// - Parametrised registered successor to the combinational FORWARD unit: carries an ALU operand/result

---
 rtl/forward_pipe_pkg.sv | 20 ++
 rtl/forward_pipe_if.sv | 23 ++
 rtl/forward_pipe_stage.sv | 55 +++++
 rtl/forward_pipe.sv | 106 ++++++++++
 tb/tb_forward_pipe.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/forward_pipe_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Package   : fwd_pkg                                                       |
// | Purpose   : Shared limits and helpers for the forward_pipe slice chain.   |
// | Contents  : FWD_MAX_STAGES, FWD_STALL_CNT_W, fwd_occ_width()              |
// | Revision  : 1.0 - initial release                                         |
// +---------------------------------------------------------------------------+
package fwd_pkg;

  localparam int FWD_MAX_STAGES  = 8;
  localparam int FWD_STALL_CNT_W = 16;

  // Width needed to count 0..stages valid slices.
  function automatic int fwd_occ_width(input int stages);
    if (stages < 1) return 1;
    return $clog2(stages + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/forward_pipe_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Interface : forward_pipe_if                                               |
// | Purpose   : One valid/ready word stream.                                  |
// | Signals   : data  - word carried by the stream                            |
// |             valid - data is meaningful this cycle                         |
// |             ready - receiver accepts data this cycle                      |
// | Modports  : master drives data/valid, slave drives ready                  |
// | Revision  : 1.0 - initial release                                         |
// +---------------------------------------------------------------------------+
interface forward_pipe_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface
`default_nettype wire

// File: rtl/forward_pipe_stage.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module    : forward_stage                                                 |
// | Purpose   : One elastic {valid,data} register slice.                      |
// | Ports     : clk, rst_n (async, active-low)                                |
// |             flush               - drop the held word                      |
// |             up_valid/up_data    - word offered from upstream              |
// |             up_ready            - slice loads this cycle                  |
// |             dn_valid/dn_data    - held word                               |
// |             dn_ready            - downstream can take the held word       |
// | Revision  : 1.0 - initial release                                         |
// +---------------------------------------------------------------------------+
module forward_stage
  import fwd_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  up_valid,
  input  logic [DATA_WIDTH-1:0] up_data,
  output logic                  up_ready,
  output logic                  dn_valid,
  output logic [DATA_WIDTH-1:0] dn_data,
  input  logic                  dn_ready
);

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;

  // Empty slice, or a slice whose word moves on this cycle, can take a new one.
  assign up_ready = ~valid_q | dn_ready;
  assign dn_valid = valid_q;
  assign dn_data  = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (up_ready) begin
        valid_q <= up_valid;
      end
      // Data only moves with a real word; an empty slice keeps stale data.
      if (up_ready && up_valid && !flush) begin
        data_q <= up_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/forward_pipe.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module    : forward_pipe                                                  |
// | Purpose   : STAGES-deep elastic register pipe for ALU operands/results,   |
// |             bubble-collapsing, full throughput, with flush and occupancy. |
// | Ports     : clk, rst_n (async, active-low)                                |
// |             up        - producer stream (slave modport)                   |
// |             dn        - consumer stream (master modport)                  |
// |             flush     - synchronous discard of all in-flight words        |
// |             occupancy - number of valid slices                            |
// |             stall_cnt - cycles with dn.valid & !dn.ready, saturating      |
// |                         (only with FORWARD_PIPE_STALL_CNT_EN defined)     |
// | Config    : FORWARD_PIPE_STALL_CNT_EN enables the stall counter port.     |
// | Revision  : 1.0 - initial release                                         |
// +---------------------------------------------------------------------------+
module forward_pipe
  import fwd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STAGES     = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  forward_pipe_if.slave                       up,
  forward_pipe_if.master                      dn,
  input  logic                                flush,
`ifdef FORWARD_PIPE_STALL_CNT_EN
  output logic [FWD_STALL_CNT_W-1:0]          stall_cnt,
`endif
  output logic [fwd_occ_width(STAGES)-1:0]    occupancy
);

  localparam int OCC_W = fwd_occ_width(STAGES);

  logic [STAGES-1:0]     stage_v;
  logic [STAGES-1:0]     stage_up_rdy;
  logic [STAGES-1:0]     stage_dn_rdy;
  logic [DATA_WIDTH-1:0] stage_d [STAGES];

  // Downstream ready of slice i is computed directly from the registered
  // valids: it is set when the consumer is ready or any later slice is
  // empty. This avoids a combinational chain through the slice instances.
  always_comb begin
    logic hole;
    hole         = 1'b0;
    stage_dn_rdy = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      stage_dn_rdy[i] = dn.ready | hole;
      hole            = hole | ~stage_v[i];
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic                  src_v;
    logic [DATA_WIDTH-1:0] src_d;

    if (i == 0) begin : g_head
      assign src_v = up.valid;
      assign src_d = up.data;
    end else begin : g_body
      assign src_v = stage_v[i-1];
      assign src_d = stage_d[i-1];
    end

    forward_stage #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .up_valid (src_v),
      .up_data  (src_d),
      .up_ready (stage_up_rdy[i]),
      .dn_valid (stage_v[i]),
      .dn_data  (stage_d[i]),
      .dn_ready (stage_dn_rdy[i])
    );
  end

  // Every slice's ready means "this slice or something after it can move",
  // so the OR over all slices equals the input slice's ready.
  assign up.ready = |stage_up_rdy;
  assign dn.valid = stage_v[STAGES-1];
  assign dn.data  = stage_d[STAGES-1];

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < STAGES; i++) begin
      occupancy = occupancy + OCC_W'(stage_v[i]);
    end
  end

`ifdef FORWARD_PIPE_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (flush) begin
      stall_cnt <= '0;
    end else if (dn.valid && !dn.ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + FWD_STALL_CNT_W'(1);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_forward_pipe.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module    : tb_forward_pipe                                               |
// | Purpose   : Self-checking bench for forward_pipe (DATA_WIDTH=8, STAGES=2).|
// | Revision  : 1.0 - initial release                                         |
// +---------------------------------------------------------------------------+
module tb_forward_pipe;

  localparam int DW = 8;
  localparam int S  = 2;
  localparam int OW = $clog2(S + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush;
  logic [OW-1:0] occupancy;
`ifdef FORWARD_PIPE_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  always #5 clk = ~clk;

  forward_pipe_if #(.DATA_WIDTH(DW)) up_if ();
  forward_pipe_if #(.DATA_WIDTH(DW)) dn_if ();

  forward_pipe #(
    .DATA_WIDTH (DW),
    .STAGES     (S)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .up        (up_if),
    .dn        (dn_if),
    .flush     (flush),
`ifdef FORWARD_PIPE_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .occupancy (occupancy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Words in flight, oldest first, each with the slice index it sits in.
  int         q_pos[$];
  logic [7:0] q_dat[$];
  int         m_stall;

  function automatic bit m_out_valid();
    if (q_pos.size() == 0) return 1'b0;
    return q_pos[0] == S - 1;
  endfunction

  task automatic model_reset();
    q_pos.delete();
    q_dat.delete();
    m_stall = 0;
  endtask

  task automatic model_edge(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
    bit ov;
    bit ir;
    int lim;
    ov = m_out_valid();
    ir = ordy || (q_pos.size() < S);
    if (fl) m_stall = 0;
    else if (ov && !ordy && m_stall < 65535) m_stall++;
    if (ov && ordy) begin
      void'(q_pos.pop_front());
      void'(q_dat.pop_front());
    end
    if (fl) begin
      q_pos.delete();
      q_dat.delete();
    end else begin
      // A word advances one slice unless the slot ahead is still taken.
      for (int k = 0; k < q_pos.size(); k++) begin
        lim = (k == 0) ? S : q_pos[k-1];
        if (q_pos[k] + 1 < lim) q_pos[k] = q_pos[k] + 1;
      end
      if (iv && ir) begin
        q_pos.push_back(0);
        q_dat.push_back(id);
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " in_ready"}, 32'(up_if.ready), 32'(dn_if.ready || (q_pos.size() < S)));
    chk({tag, " out_valid"}, 32'(dn_if.valid), 32'(m_out_valid()));
    if (m_out_valid()) chk({tag, " out_data"}, 32'(dn_if.data), 32'(q_dat[0]));
    chk({tag, " occupancy"}, 32'(occupancy), 32'(q_pos.size()));
`ifdef FORWARD_PIPE_STALL_CNT_EN
    chk({tag, " stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
`endif
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
    up_if.valid = iv;
    up_if.data  = id;
    dn_if.ready = ordy;
    flush       = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(up_if.valid, up_if.data, dn_if.ready, flush);
    #1;
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       fl;
    logic       ir;
    logic       ov;
    logic [7:0] od;
    int         occ;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic iv, input logic [7:0] id, input logic ordy, input logic fl,
                     input logic ir, input logic ov, input logic [7:0] od, input int occ);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
    v.ir = ir; v.ov = ov; v.od = od; v.occ = occ;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    // streaming, OUT_READY=1
    add(1, 8'h11, 1, 0,  1, 0, 8'h00, 0);
    add(1, 8'h22, 1, 0,  1, 0, 8'h00, 1);
    add(1, 8'h33, 1, 0,  1, 1, 8'h11, 2);
    add(0, 8'h00, 1, 0,  1, 1, 8'h22, 2);
    add(0, 8'h00, 1, 0,  1, 1, 8'h33, 1);
    add(0, 8'h00, 1, 0,  1, 0, 8'h00, 0);
    // backpressure
    add(1, 8'hA5, 0, 0,  1, 0, 8'h00, 0);
    add(1, 8'h5A, 0, 0,  1, 0, 8'h00, 1);
    add(1, 8'hC3, 0, 0,  0, 1, 8'hA5, 2);
    add(1, 8'hC3, 1, 0,  1, 1, 8'hA5, 2);
    add(0, 8'h00, 1, 0,  1, 1, 8'h5A, 2);
    add(0, 8'h00, 1, 0,  1, 1, 8'hC3, 1);
    add(0, 8'h00, 1, 0,  1, 0, 8'h00, 0);
    // flush with two words held
    add(1, 8'h01, 0, 0,  1, 0, 8'h00, 0);
    add(1, 8'h02, 0, 0,  1, 0, 8'h00, 1);
    add(1, 8'hFF, 0, 1,  0, 1, 8'h01, 2);
    add(0, 8'h00, 1, 0,  1, 0, 8'h00, 0);
    // flush coinciding with an accepted input word
    add(1, 8'hEE, 1, 0,  1, 0, 8'h00, 0);
    add(1, 8'hFF, 1, 1,  1, 0, 8'h00, 1);
    add(0, 8'h00, 1, 0,  1, 0, 8'h00, 0);
    add(0, 8'h00, 1, 0,  1, 0, 8'h00, 0);
    // bubble collapse: word sits in the output slice, input slice empty
    add(1, 8'h3C, 0, 0,  1, 0, 8'h00, 0);
    add(0, 8'h00, 0, 0,  1, 0, 8'h00, 1);
    add(1, 8'h7E, 0, 0,  1, 1, 8'h3C, 1);
    add(0, 8'h00, 0, 0,  0, 1, 8'h3C, 2);
    add(0, 8'h00, 1, 0,  1, 1, 8'h3C, 2);
    add(0, 8'h00, 1, 0,  1, 1, 8'h7E, 1);
    add(0, 8'h00, 1, 0,  1, 0, 8'h00, 0);

    // reset state
    drive(0, 8'h00, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(dn_if.valid), 32'd0);
    chk("reset out_data", 32'(dn_if.data), 32'd0);
    chk("reset occupancy", 32'(occupancy), 32'd0);
`ifdef FORWARD_PIPE_STALL_CNT_EN
    chk("reset stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    chk("reset in_ready", 32'(up_if.ready), 32'd1);

    // table-driven directed vectors
    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].iv, vecs[k].id, vecs[k].ordy, vecs[k].fl);
      #1;
      chk($sformatf("vec%0d in_ready", k), 32'(up_if.ready), 32'(vecs[k].ir));
      chk($sformatf("vec%0d out_valid", k), 32'(dn_if.valid), 32'(vecs[k].ov));
      if (vecs[k].ov) chk($sformatf("vec%0d out_data", k), 32'(dn_if.data), 32'(vecs[k].od));
      chk($sformatf("vec%0d occupancy", k), 32'(occupancy), 32'(vecs[k].occ));
      tick();
    end

    // asynchronous reset with two words in flight
    drive(1, 8'hAA, 0, 0); tick();
    drive(1, 8'hBB, 0, 0); tick();
    drive(0, 8'h00, 0, 0);
    #1;
    chk("pre-reset occupancy", 32'(occupancy), 32'd2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async reset out_valid", 32'(dn_if.valid), 32'd0);
    chk("async reset out_data", 32'(dn_if.data), 32'd0);
    chk("async reset occupancy", 32'(occupancy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    chk("post-reset in_ready", 32'(up_if.ready), 32'd1);

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 6,
            $urandom_range(0, 19) == 0);
      #1;
      check_model("rnd");
      tick();
    end

`ifdef FORWARD_PIPE_STALL_CNT_EN
    // stall counter: five stalled cycles, then flush
    drive(0, 8'h00, 0, 1); #1; check_model("stall flush0"); tick();
    drive(1, 8'h55, 0, 0); #1; check_model("stall load"); tick();
    drive(0, 8'h00, 0, 0);
    n = 0;
    while (!dn_if.valid && n < 10) begin
      tick();
      n++;
    end
    chk("stall wait out_valid", 32'(dn_if.valid), 32'd1);
    chk("stall start", 32'(stall_cnt), 32'd0);
    repeat (5) tick();
    chk("stall after 5", 32'(stall_cnt), 32'd5);
    drive(0, 8'h00, 0, 1);
    tick();
    chk("stall after flush", 32'(stall_cnt), 32'd0);
    chk("occupancy after flush", 32'(occupancy), 32'd0);
`else
    n = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
